// File: rtl/fft_pkg.sv
// Shared types and arithmetic helpers for the R2^2 SDF FFT pipeline stages.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        COMB  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int WIDTH_DEF = 16;
    localparam int DELAY_DEF = 8;

    // Widest sample the helper supports; callers work in WIDTH+1 bits sign-extended to SAT_W+1.
    localparam int SAT_W = 32;

    // Reduce a WIDTH+1 bit add/sub result back to WIDTH bits: floor halving or clamping.
    function automatic logic signed [SAT_W-1:0] sat_scale(
        input logic signed [SAT_W:0] v,
        input int                    w,
        input logic                  scale
    );
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        logic signed [SAT_W:0] r;
        hi = $signed({(SAT_W+1){1'b1}} >> (SAT_W + 2 - w));
        lo = ~hi;
        r  = v;
        if (scale) begin
            r = v >>> 1;
        end else if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end
        return r[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/bf2_addsub.sv
// Complex radix-2 add/sub: sum = a + b, diff = a - b, each part reduced back to WIDTH bits.
module bf2_addsub
    import fft_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter bit SCALE = 1'b1
) (
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] b_re,
    input  logic signed [WIDTH-1:0] b_im,
    output logic signed [WIDTH-1:0] sum_re,
    output logic signed [WIDTH-1:0] sum_im,
    output logic signed [WIDTH-1:0] diff_re,
    output logic signed [WIDTH-1:0] diff_im
);

    logic signed [WIDTH:0] s_re;
    logic signed [WIDTH:0] s_im;
    logic signed [WIDTH:0] d_re;
    logic signed [WIDTH:0] d_im;

    always_comb begin
        s_re = {a_re[WIDTH-1], a_re} + {b_re[WIDTH-1], b_re};
        s_im = {a_im[WIDTH-1], a_im} + {b_im[WIDTH-1], b_im};
        d_re = {a_re[WIDTH-1], a_re} - {b_re[WIDTH-1], b_re};
        d_im = {a_im[WIDTH-1], a_im} - {b_im[WIDTH-1], b_im};
    end

    assign sum_re  = WIDTH'(sat_scale((SAT_W+1)'(s_re), WIDTH, SCALE));
    assign sum_im  = WIDTH'(sat_scale((SAT_W+1)'(s_im), WIDTH, SCALE));
    assign diff_re = WIDTH'(sat_scale((SAT_W+1)'(d_re), WIDTH, SCALE));
    assign diff_im = WIDTH'(sat_scale((SAT_W+1)'(d_im), WIDTH, SCALE));

endmodule

// File: rtl/sdf_bf2_stage.sv
// Radix-2 SDF butterfly stage: frame counter, feedback control and output register around
// an external delay line.
//
//  state | meaning
//  IDLE  | no frame in progress, delay line held clear
//  FILL  | first half: samples go into the delay line, pending differences drain out
//  COMB  | second half: sums go out, differences go into the delay line
//  FLUSH | no input: drain the pending differences, shift zeros in
module sdf_bf2_stage
    import fft_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DELAY = DELAY_DEF,
    parameter bit SCALE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] In_Re,
    input  logic signed [WIDTH-1:0] In_Im,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    output logic signed [WIDTH-1:0] Dl_In_Re,
    output logic signed [WIDTH-1:0] Dl_In_Im,
    output logic                    Dl_Enable,
    input  logic signed [WIDTH-1:0] Dl_Out_Re,
    input  logic signed [WIDTH-1:0] Dl_Out_Im,
    output logic signed [WIDTH-1:0] Out_Re,
    output logic signed [WIDTH-1:0] Out_Im,
    output logic                    Out_Valid,
    output logic                    Frame_Err
);

    localparam int              CW         = $clog2(2 * DELAY);
    localparam logic [CW-1:0]   LAST_HALF  = CW'(DELAY - 1);
    localparam logic [CW-1:0]   LAST_FRAME = CW'(2 * DELAY - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            pend;
    logic            accept;
    logic            boundary;

    logic signed [WIDTH-1:0] sum_re;
    logic signed [WIDTH-1:0] sum_im;
    logic signed [WIDTH-1:0] diff_re;
    logic signed [WIDTH-1:0] diff_im;

    bf2_addsub #(
        .WIDTH (WIDTH),
        .SCALE (SCALE)
    ) u_addsub (
        .a_re    (Dl_Out_Re),
        .a_im    (Dl_Out_Im),
        .b_re    (In_Re),
        .b_im    (In_Im),
        .sum_re  (sum_re),
        .sum_im  (sum_im),
        .diff_re (diff_re),
        .diff_im (diff_im)
    );

    assign In_Ready = (state != FLUSH);
    assign accept   = In_Valid & In_Ready;

    // COMB has just finished and no new frame follows: this cycle is the first flush cycle.
    assign boundary = (state == FILL) && (cnt == '0) && pend && !In_Valid;

    always_comb begin
        Dl_Enable = 1'b0;
        Dl_In_Re  = '0;
        Dl_In_Im  = '0;
        case (state)
            IDLE, FILL: begin
                if (accept) begin
                    Dl_Enable = 1'b1;
                    Dl_In_Re  = In_Re;
                    Dl_In_Im  = In_Im;
                end else if (boundary) begin
                    Dl_Enable = 1'b1;
                end
            end
            COMB: begin
                if (accept) begin
                    Dl_Enable = 1'b1;
                    Dl_In_Re  = diff_re;
                    Dl_In_Im  = diff_im;
                end
            end
            FLUSH: begin
                Dl_Enable = 1'b1;
            end
            default: begin
                Dl_Enable = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend      <= 1'b0;
            Out_Re    <= '0;
            Out_Im    <= '0;
            Out_Valid <= 1'b0;
            Frame_Err <= 1'b0;
        end else begin
            Out_Valid <= 1'b0;
            Frame_Err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= FILL;
                        cnt   <= CW'(1);
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (pend) begin
                            Out_Re    <= Dl_Out_Re;
                            Out_Im    <= Dl_Out_Im;
                            Out_Valid <= 1'b1;
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST_HALF) begin
                            state <= COMB;
                            pend  <= 1'b0;
                        end
                    end else if (boundary) begin
                        Out_Re    <= Dl_Out_Re;
                        Out_Im    <= Dl_Out_Im;
                        Out_Valid <= 1'b1;
                        cnt       <= CW'(1);
                        state     <= FLUSH;
                    end else begin
                        state     <= IDLE;
                        cnt       <= '0;
                        pend      <= 1'b0;
                        Frame_Err <= 1'b1;
                    end
                end
                COMB: begin
                    if (accept) begin
                        Out_Re    <= sum_re;
                        Out_Im    <= sum_im;
                        Out_Valid <= 1'b1;
                        cnt       <= cnt + CW'(1);
                        if (cnt == LAST_FRAME) begin
                            state <= FILL;
                            pend  <= 1'b1;
                        end
                    end else begin
                        state     <= IDLE;
                        cnt       <= '0;
                        pend      <= 1'b0;
                        Frame_Err <= 1'b1;
                    end
                end
                FLUSH: begin
                    Out_Re    <= Dl_Out_Re;
                    Out_Im    <= Dl_Out_Im;
                    Out_Valid <= 1'b1;
                    if (cnt == LAST_HALF) begin
                        state <= IDLE;
                        cnt   <= '0;
                        pend  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    pend  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdf_bf2_stage.sv
// Directed bench for sdf_bf2_stage: a saturating and a scaling instance, each with its own delay line.
module tb_sdf_bf2_stage;

    localparam int W = 16;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;

    always #5 clk = ~clk;

    logic                rdy0, dl_en0, ov0, ferr0;
    logic signed [W-1:0] dlin0_re, dlin0_im, dlout0_re, dlout0_im, out0_re, out0_im;
    logic                rdy1, dl_en1, ov1, ferr1;
    logic signed [W-1:0] dlin1_re, dlin1_im, dlout1_re, dlout1_im, out1_re, out1_im;

    sdf_bf2_stage #(.WIDTH(W), .DELAY(D), .SCALE(1'b0)) dut_sat (
        .clk(clk), .rst(rst), .In_Re(in_re), .In_Im(in_im), .In_Valid(in_valid),
        .In_Ready(rdy0), .Dl_In_Re(dlin0_re), .Dl_In_Im(dlin0_im), .Dl_Enable(dl_en0),
        .Dl_Out_Re(dlout0_re), .Dl_Out_Im(dlout0_im), .Out_Re(out0_re), .Out_Im(out0_im),
        .Out_Valid(ov0), .Frame_Err(ferr0)
    );

    sdf_bf2_stage #(.WIDTH(W), .DELAY(D), .SCALE(1'b1)) dut_scl (
        .clk(clk), .rst(rst), .In_Re(in_re), .In_Im(in_im), .In_Valid(in_valid),
        .In_Ready(rdy1), .Dl_In_Re(dlin1_re), .Dl_In_Im(dlin1_im), .Dl_Enable(dl_en1),
        .Dl_Out_Re(dlout1_re), .Dl_Out_Im(dlout1_im), .Out_Re(out1_re), .Out_Im(out1_im),
        .Out_Valid(ov1), .Frame_Err(ferr1)
    );

    // External delay lines: shift on enable, clear while enable is low.
    logic signed [W-1:0] dl0_re [D];
    logic signed [W-1:0] dl0_im [D];
    logic signed [W-1:0] dl1_re [D];
    logic signed [W-1:0] dl1_im [D];

    always_ff @(posedge clk) begin
        for (int i = 0; i < D; i++) begin
            if (!dl_en0) begin
                dl0_re[i] <= '0;
                dl0_im[i] <= '0;
            end else if (i == 0) begin
                dl0_re[i] <= dlin0_re;
                dl0_im[i] <= dlin0_im;
            end else begin
                dl0_re[i] <= dl0_re[i-1];
                dl0_im[i] <= dl0_im[i-1];
            end
            if (!dl_en1) begin
                dl1_re[i] <= '0;
                dl1_im[i] <= '0;
            end else if (i == 0) begin
                dl1_re[i] <= dlin1_re;
                dl1_im[i] <= dlin1_im;
            end else begin
                dl1_re[i] <= dl1_re[i-1];
                dl1_im[i] <= dl1_im[i-1];
            end
        end
    end

    assign dlout0_re = dl0_re[D-1];
    assign dlout0_im = dl0_im[D-1];
    assign dlout1_re = dl1_re[D-1];
    assign dlout1_im = dl1_im[D-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int q0_re[$], q0_im[$], q1_re[$], q1_im[$], qt[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ov0) begin
            q0_re.push_back(int'(out0_re));
            q0_im.push_back(int'(out0_im));
            qt.push_back(cyc);
        end
        if (ov1) begin
            q1_re.push_back(int'(out1_re));
            q1_im.push_back(int'(out1_im));
        end
        if (ferr0) ferr_cnt = ferr_cnt + 1;
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int re, input int im);
        @(negedge clk);
        in_valid = v;
        in_re    = W'(re);
        in_im    = W'(im);
    endtask

    task automatic clear_q();
        q0_re.delete(); q0_im.delete(); q1_re.delete(); q1_im.delete(); qt.delete();
        ferr_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_re"}, out0_re, 0);
        check({tag, "_out_im"}, out0_im, 0);
        check({tag, "_out_valid"}, ov0, 0);
        check({tag, "_frame_err"}, ferr0, 0);
        check({tag, "_in_ready"}, rdy0, 1);
        check({tag, "_dl_enable"}, dl_en0, 0);
        check({tag, "_dl_in_re"}, dlin0_re, 0);
        check({tag, "_scl_out_re"}, out1_re, 0);
        check({tag, "_scl_out_valid"}, ov1, 0);
    endtask

    // Ramp frame x[n]=n: sums 8,10,..,22 then differences -8 (halved for the scaling instance).
    task automatic check_ramp(input string tag, input int base);
        for (int k = 0; k < D; k++) begin
            check({tag, "_sum"},      q0_re[base+k],   8 + 2*k);
            check({tag, "_diff"},     q0_re[base+D+k], -8);
            check({tag, "_scl_sum"},  q1_re[base+k],   4 + k);
            check({tag, "_scl_diff"}, q1_re[base+D+k], -4);
        end
        check({tag, "_im"}, q0_im[base], 0);
        check({tag, "_contiguous"}, qt[base+2*D-1] - qt[base], 2*D - 1);
    endtask

    task automatic run_ramp(input string tag);
        clear_q();
        for (int n = 0; n < 2*D; n++) drive(1'b1, n, 0);
        repeat (12) drive(1'b0, 0, 0);
        check({tag, "_count"}, q0_re.size(), 2*D);
        check({tag, "_scl_count"}, q1_re.size(), 2*D);
        if (q0_re.size() == 2*D && q1_re.size() == 2*D) check_ramp(tag, 0);
    endtask

    task automatic sat_frame(input string tag,
                             input int ra, input int ia, input int rb, input int ib,
                             input int s_re, input int s_im, input int d_re, input int d_im,
                             input int c_re, input int c_im, input int e_re, input int e_im);
        clear_q();
        for (int n = 0; n < D; n++) drive(1'b1, ra, ia);
        for (int n = 0; n < D; n++) drive(1'b1, rb, ib);
        repeat (12) drive(1'b0, 0, 0);
        check({tag, "_count"}, q0_re.size(), 2*D);
        if (q0_re.size() == 2*D && q1_re.size() == 2*D) begin
            check({tag, "_sat_sum_re"},   q0_re[0], s_re);
            check({tag, "_sat_sum_im"},   q0_im[0], s_im);
            check({tag, "_sat_diff_re"},  q0_re[D], d_re);
            check({tag, "_sat_diff_im"},  q0_im[D], d_im);
            check({tag, "_scl_sum_re"},   q1_re[0], c_re);
            check({tag, "_scl_sum_im"},   q1_im[0], c_im);
            check({tag, "_scl_diff_re"},  q1_re[D], e_re);
            check({tag, "_scl_diff_im"},  q1_im[D], e_im);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_ramp("single");

        // Back-to-back: ramp then constant 100; differences drain inside the second FILL.
        clear_q();
        for (int n = 0; n < 2*D; n++) drive(1'b1, n, 0);
        for (int n = 0; n < 2*D; n++) begin
            drive(1'b1, 100, 0);
            #1 check("b2b_in_ready", rdy0, 1);
        end
        repeat (12) drive(1'b0, 0, 0);
        check("b2b_count", q0_re.size(), 4*D);
        if (q0_re.size() == 4*D && q1_re.size() == 4*D) begin
            check_ramp("b2b_f1", 0);
            for (int k = 0; k < D; k++) begin
                check("b2b_f2_sum",      q0_re[2*D+k], 200);
                check("b2b_f2_diff",     q0_re[3*D+k], 0);
                check("b2b_f2_scl_sum",  q1_re[2*D+k], 100);
            end
            check("b2b_contiguous", qt[4*D-1] - qt[0], 4*D - 1);
        end

        // Saturation / floor-halving corners on both parts.
        sat_frame("satA", 32767, 32767, 32767, -32768,
                  32767, -1, 0, 32767,
                  32767, -1, 0, 32767);
        sat_frame("satB", -32768, -32768, -32767, 32767,
                  -32768, -1, -1, -32768,
                  -32768, -1, -1, -32768);

        // In_Valid drop at index 11.
        clear_q();
        for (int n = 0; n < 11; n++) drive(1'b1, n, 0);
        drive(1'b0, 0, 0);
        @(posedge clk);
        #1;
        check("drop_frame_err", ferr0, 1);
        check("drop_dl_enable", dl_en0, 0);
        repeat (15) drive(1'b0, 0, 0);
        check("drop_err_pulses", ferr_cnt, 1);
        check("drop_out_count", q0_re.size(), 3);
        if (q0_re.size() == 3) begin
            check("drop_sum8", q0_re[0], 8);
            check("drop_sum10", q0_re[2], 12);
        end
        run_ramp("after_drop");

        // In_Valid held during FLUSH must not be consumed.
        clear_q();
        for (int n = 0; n < 2*D; n++) drive(1'b1, n, 0);
        drive(1'b0, 0, 0);
        for (int k = 0; k < D-1; k++) begin
            drive(1'b1, 50, 0);
            #1 check("flush_in_ready", rdy0, 0);
        end
        drive(1'b1, 50, 0);
        #1;
        check("flush_end_ready", rdy0, 1);
        check("flush_end_dl_en", dl_en0, 1);
        for (int n = 1; n < 2*D; n++) drive(1'b1, 50, 0);
        repeat (12) drive(1'b0, 0, 0);
        check("flush_count", q0_re.size(), 4*D);
        if (q0_re.size() == 4*D && q1_re.size() == 4*D) begin
            check_ramp("flush_f1", 0);
            check("flush_f2_sum",     q0_re[2*D], 100);
            check("flush_f2_scl_sum", q1_re[2*D], 50);
            check("flush_f2_diff",    q0_re[3*D], 0);
            check("flush_gap", qt[2*D] - qt[2*D-1], D + 1);
        end

        // Reset mid-COMB, then a clean frame.
        for (int n = 0; n < 12; n++) drive(1'b1, n, 0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        run_ramp("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
